fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-side pointer and flag controller for the asynchronous FIFO in the UART system, living entirely in the write-clock domain. It turns write requests into a binary memory address and a registered Gray-coded write pointer, which goes to the read domain's double-flop synchronizer. It consumes the read pointer already synchronized into this domain, and from it generates full, almost-full, fill level and a sticky overflow flag.

## Interface
- ADDR_WD, 3: memory address width; FIFO depth DEPTH = 2^ADDR_WD; must be >= 2.
- PTR_WD, ADDR_WD+1: pointer width (one wrap bit above the address).
- AF_THRESH, 2^ADDR_WD-1: ALMOST_FULL asserts when LEVEL >= AF_THRESH; legal range 1..DEPTH.

Ports:
- CLK  in  1  write-domain clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- W_INC  in  1  write request, one word per cycle while high.
- RD_PTR_SYNC  in  PTR_WD  Gray read pointer, already synchronized into CLK domain.
- OVF_CLR  in  1  synchronous clear of OVF.
- W_EN  out  1  memory write enable = W_INC & ~FULL (combinational).
- W_ADDR  out  ADDR_WD  memory write address = low ADDR_WD bits of binary write pointer.
- WR_PTR  out  PTR_WD  registered Gray write pointer, driven to the read-domain synchronizer.
- FULL  out  1  FIFO full.
- ALMOST_FULL  out  1  LEVEL >= AF_THRESH.
- LEVEL  out  PTR_WD  write-side occupancy estimate, 0..DEPTH.
- OVF  out  1  sticky: write attempted while FULL.

## Operation
- State: binary pointer WBIN[PTR_WD-1:0], Gray register WR_PTR, flag register OVF.
- Accepted write: W_INC=1 and FULL=0.
  - WBIN <= WBIN+1, modulo 2^PTR_WD (wraps silently).
  - WR_PTR <= (WBIN+1) ^ ((WBIN+1)>>1).
  - WR_PTR is always a register output, never combinational, so it is glitch-free and changes by one bit per increment.
- Rejected write: W_INC=1 and FULL=1.
  - Pointers hold.
  - W_EN=0.
  - OVF <= 1.
- OVF priority: if OVF_CLR and a rejected write occur in the same cycle, set wins and OVF stays 1.
- FULL = (WR_PTR == {~RD_PTR_SYNC[PTR_WD-1:PTR_WD-2], RD_PTR_SYNC[PTR_WD-3:0]}). Combinational from registers only.
- RBIN = Gray-to-binary of RD_PTR_SYNC: RBIN[MSB] = G[MSB]; RBIN[i] = RBIN[i+1] ^ G[i].
- LEVEL = (WBIN - RBIN) mod 2^PTR_WD, PTR_WD-bit unsigned.
  - LEVEL = DEPTH exactly when FULL=1.
  - LEVEL is pessimistic (over-reports) by the synchronizer latency.
- ALMOST_FULL = (LEVEL >= AF_THRESH). Combinational.
- No read-side logic; empty detection belongs to the read controller.

## Timing
- Reset (RST=1, asynchronous):
  - WBIN=0, WR_PTR=0, OVF=0, W_ADDR=0.
  - With RD_PTR_SYNC=0: FULL=0, LEVEL=0, ALMOST_FULL=0.
- Reset mid-operation: all registers clear immediately, regardless of pending W_INC.
- Deassertion: first write is accepted on the first rising edge after RST falls.
- Write latency: W_ADDR/W_EN are valid in the same cycle W_INC is high. Memory writes at W_ADDR on that edge, and W_ADDR/WR_PTR advance on that same edge.
- FULL assertion: FULL rises in the cycle after the DEPTH-th unmatched accepted write, so no accepted write is lost.
- FULL release: FULL falls combinationally in the cycle RD_PTR_SYNC changes. A write in that cycle is accepted.
- Throughput: one write per cycle sustained while not FULL.
- Cross-domain visibility: WR_PTR reaches the read domain two read clocks later through the external synchronizer. This block adds no further delay.

## Test plan
- **Reset values:** assert RST with W_INC=1 held → WR_PTR=0000, W_ADDR=0, FULL=0, LEVEL=0, OVF=0. Release RST → first edge gives WR_PTR=0001.
- **Fill:** ADDR_WD=3, RD_PTR_SYNC=0000, 8 consecutive writes →
  - W_ADDR sequence 0..7.
  - WR_PTR Gray sequence 0001,0011,0010,0110,0111,0101,0100,1100.
  - FULL=1 and LEVEL=8 after the 8th write.
  - ALMOST_FULL=1 from LEVEL=7.
- **Overflow:** with FULL=1, one extra W_INC → W_EN=0, WR_PTR stays 1100, OVF=1. Then OVF_CLR together with another W_INC → OVF stays 1. Then OVF_CLR alone → OVF=0.
- **Release:** from full, drive RD_PTR_SYNC=0001 → FULL=0 and LEVEL=7 in the same cycle. A write in that cycle is accepted and gives WR_PTR=1101, FULL=1.
- **Wrap-around:** 16 accepted writes total, with RD_PTR_SYNC tracking → WBIN wraps to 0, WR_PTR=0000, LEVEL stays correct. Check a case with RD_PTR_SYNC=1000 (bin 15) and WBIN=3 → LEVEL=4.
- **Reset mid-burst:** pulse RST asynchronously between edges during a write burst → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer and flag controller for the UART asynchronous FIFO.
// Produces the memory write address, the registered Gray write pointer, and full/level/overflow status.
module fifo_wr_ctrl #(
    parameter int ADDR_WD   = 3,
    parameter int PTR_WD    = ADDR_WD + 1,
    parameter int AF_THRESH = 2**ADDR_WD - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_inc,
    input  logic [PTR_WD-1:0] rd_ptr_sync,
    input  logic              ovf_clr,
    output logic              w_en,
    output logic [ADDR_WD-1:0] w_addr,
    output logic [PTR_WD-1:0] wr_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [PTR_WD-1:0] level,
    output logic              ovf
);

    localparam logic [PTR_WD-1:0] AF_LEVEL = PTR_WD'(AF_THRESH);

    logic [PTR_WD-1:0] wbin;
    logic [PTR_WD-1:0] wbin_next;
    logic [PTR_WD-1:0] rbin;

    assign wbin_next = wbin + PTR_WD'(1);

    // Full when the read pointer is exactly one lap behind: in Gray code that
    // means the top two bits differ and the rest match.
    assign full = (wr_ptr == {~rd_ptr_sync[PTR_WD-1 -: 2], rd_ptr_sync[PTR_WD-3:0]});

    assign w_en   = w_inc & ~full;
    assign w_addr = wbin[ADDR_WD-1:0];

    // NOTE: every bit of rbin is assigned on each pass, so no latch is inferred.
    always_comb begin
        rbin[PTR_WD-1] = rd_ptr_sync[PTR_WD-1];
        for (int i = PTR_WD - 2; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ rd_ptr_sync[i];
        end
    end

    assign level       = wbin - rbin;
    assign almost_full = (level >= AF_LEVEL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin   <= '0;
            wr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (w_en) begin
                wbin   <= wbin_next;
                wr_ptr <= wbin_next ^ (wbin_next >> 1);
            end
            // A rejected write outranks a simultaneous clear.
            if (w_inc && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
